// File: rtl/stgreg_skid_pkg.sv
// ---------------------------------------------------------------------------
// stgreg_skid_pkg
// Shared definitions for the skid-buffered pipeline stage register.
//   - SIZE_ADDR / SIZE_DATA: default pc/instr widths. The shared sizes header
//     normally provides them. The fallbacks below apply only when that header
//     is not part of the build.
//   - stgreg_state_t: 2-bit stage state encoding
//     (STGREG_EMPTY / STGREG_BUSY / STGREG_FULL).
// ---------------------------------------------------------------------------
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

package stgreg_skid_pkg;

  // EMPTY: M invalid. BUSY: M valid, S empty. FULL: M and S valid.
  typedef enum logic [1:0] {
    STGREG_EMPTY = 2'b00,
    STGREG_BUSY  = 2'b01,
    STGREG_FULL  = 2'b10
  } stgreg_state_t;

endpackage

// File: rtl/stgreg_slot.sv
// ---------------------------------------------------------------------------
// stgreg_slot
// One pc+instr holding register, used for both the main register (M) and the
// skid register (S) of stgreg_skid.
// Ports:
//   iw_clk    in   clock, rising edge
//   iw_rst_n  in   asynchronous active-low reset to {0, NOP_INSTR}
//   iw_clr    in   synchronous clear to {0, NOP_INSTR}; wins over load
//   iw_load   in   load enable
//   iw_pc     in   pc to load
//   iw_instr  in   instr to load
//   ow_pc     out  stored pc
//   ow_instr  out  stored instr
// ---------------------------------------------------------------------------
module stgreg_slot #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_clr,
  input  logic              iw_load,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr
);

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      ow_pc    <= '0;
      ow_instr <= NOP_INSTR;
    end else if (iw_clr) begin
      ow_pc    <= '0;
      ow_instr <= NOP_INSTR;
    end else if (iw_load) begin
      ow_pc    <= iw_pc;
      ow_instr <= iw_instr;
    end
  end

endmodule

// File: rtl/stgreg_skid.sv
// ---------------------------------------------------------------------------
// stgreg_skid
// Pipeline stage register for a pc/instr pair with a valid/ready handshake
// and a two-entry skid buffer (main register M plus skid register S). It
// sustains one transfer per cycle. ow_ready depends on the state register
// only, so it never depends combinationally on iw_ready.
// Optional feature: define STGREG_FLUSH_EN to add the synchronous iw_flush
// input. Flush empties the stage and clears M and S to {0, NOP_INSTR}.
// Ports:
//   iw_clk    in   clock, rising edge
//   iw_rst_n  in   asynchronous active-low reset
//   iw_flush  in   synchronous flush (only with STGREG_FLUSH_EN)
//   iw_valid  in   upstream payload valid
//   ow_ready  out  stage can accept (state != FULL)
//   iw_pc     in   upstream pc
//   iw_instr  in   upstream instr
//   ow_valid  out  downstream payload valid (state != EMPTY)
//   iw_ready  in   downstream accepts
//   ow_pc     out  downstream pc, from M
//   ow_instr  out  downstream instr, from M
//   ow_skid   out  S occupied (state == FULL)
// ---------------------------------------------------------------------------
module stgreg_skid #(
  parameter int                ADDR_W    = `SIZE_ADDR,
  parameter int                DATA_W    = `SIZE_DATA,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
`ifdef STGREG_FLUSH_EN
  input  logic              iw_flush,
`endif
  input  logic              iw_valid,
  output logic              ow_ready,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  output logic              ow_valid,
  input  logic              iw_ready,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic              ow_skid
);

  import stgreg_skid_pkg::*;

  stgreg_state_t     state_p0;
  stgreg_state_t     state_nxt;
  logic              acc_in;
  logic              acc_out;
  logic              m_load;
  logic              m_from_s;
  logic              s_load;
  logic              slot_clr;
  logic [ADDR_W-1:0] m_pc_d;
  logic [DATA_W-1:0] m_instr_d;
  logic [ADDR_W-1:0] s_pc;
  logic [DATA_W-1:0] s_instr;

  assign ow_valid = (state_p0 != STGREG_EMPTY);
  assign ow_ready = (state_p0 != STGREG_FULL);
  assign ow_skid  = (state_p0 == STGREG_FULL);

  assign acc_in   = iw_valid & ow_ready;
  assign acc_out  = ow_valid & iw_ready;

`ifdef STGREG_FLUSH_EN
  assign slot_clr = iw_flush;
`else
  assign slot_clr = 1'b0;
`endif

  // State register
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) state_p0 <= STGREG_EMPTY;
    else           state_p0 <= state_nxt;
  end

  // Next state and slot load controls
  always_comb begin
    state_nxt = state_p0;
    m_load    = 1'b0;
    m_from_s  = 1'b0;
    s_load    = 1'b0;
    unique case (state_p0)
      STGREG_EMPTY: begin
        if (acc_in) begin
          m_load    = 1'b1;
          state_nxt = STGREG_BUSY;
        end
      end
      STGREG_BUSY: begin
        if (acc_in && acc_out) begin
          m_load    = 1'b1;
        end else if (acc_in) begin
          // Downstream stalled: the new beat parks in S behind M.
          s_load    = 1'b1;
          state_nxt = STGREG_FULL;
        end else if (acc_out) begin
          state_nxt = STGREG_EMPTY;
        end
      end
      STGREG_FULL: begin
        // ow_ready is low here, so only the drain of M can happen.
        if (acc_out) begin
          m_load    = 1'b1;
          m_from_s  = 1'b1;
          state_nxt = STGREG_BUSY;
        end
      end
      default: state_nxt = STGREG_EMPTY;
    endcase
`ifdef STGREG_FLUSH_EN
    // Flush overrides everything. A same-cycle input is dropped, and a
    // same-cycle output has already been taken downstream.
    if (iw_flush) begin
      state_nxt = STGREG_EMPTY;
      m_load    = 1'b0;
      s_load    = 1'b0;
    end
`endif
  end

  assign m_pc_d    = m_from_s ? s_pc    : iw_pc;
  assign m_instr_d = m_from_s ? s_instr : iw_instr;

  stgreg_slot #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_slot_m (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .iw_clr   (slot_clr),
    .iw_load  (m_load),
    .iw_pc    (m_pc_d),
    .iw_instr (m_instr_d),
    .ow_pc    (ow_pc),
    .ow_instr (ow_instr)
  );

  stgreg_slot #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_slot_s (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .iw_clr   (slot_clr),
    .iw_load  (s_load),
    .iw_pc    (iw_pc),
    .iw_instr (iw_instr),
    .ow_pc    (s_pc),
    .ow_instr (s_instr)
  );

endmodule

// File: doc/stgreg_skid.md
# stgreg_skid

Parametrised pipeline stage register carrying a `pc`/`instr` pair between two pipeline stages. It is the successor to the fixed, always-loading stage latches. It adds a valid/ready handshake, back-pressure through a two-entry skid buffer, a configurable NOP payload, and an optional synchronous flush. It sits between any two stages of the core pipeline and sustains one transfer per cycle with a registered `ow_ready`.

## Interface
- `ADDR_W`, default `` `SIZE_ADDR ``: width of the pc field.
- `DATA_W`, default `` `SIZE_DATA ``: width of the instr field.
- `NOP_INSTR`, default `DATA_W'b0`: instr value loaded on reset and flush.
- `iw_clk`  in  1  single clock; all state changes on its rising edge.
- `iw_rst_n`  in  1  reset, asynchronous, active-low.
- `iw_valid`  in  1  upstream payload valid.
- `ow_ready`  out  1  stage can accept; registered, derived from state only.
- `iw_pc`  in  ADDR_W  upstream pc.
- `iw_instr`  in  DATA_W  upstream instr.
- `ow_valid`  out  1  downstream payload valid.
- `iw_ready`  in  1  downstream accepts.
- `ow_pc`  out  ADDR_W  downstream pc, driven from main register M.
- `ow_instr`  out  DATA_W  downstream instr, driven from M.
- `ow_skid`  out  1  skid register S occupied (stage FULL).
- `iw_flush`  in  1  synchronous flush; present only with `STGREG_FLUSH_EN`.

## Operation
- Accept-in is `iw_valid & ow_ready`. Accept-out is `ow_valid & iw_ready`.
- States:
  - EMPTY: M invalid.
  - BUSY: M valid, S empty.
  - FULL: M and S both valid.
- Decoded outputs:
  - `ow_valid = (state != EMPTY)`
  - `ow_ready = (state != FULL)`
  - `ow_skid = (state == FULL)`
- EMPTY: on accept-in, M ← input and go to BUSY.
- BUSY:
  - Accept-in and accept-out together: M ← input, stay BUSY.
  - Accept-in only: S ← input, go to FULL.
  - Accept-out only: go to EMPTY.
  - Neither: hold.
- FULL: no input is accepted. On accept-out, M ← S and go to BUSY.
- Payload is written only on the transitions above. In EMPTY, `ow_pc`/`ow_instr` hold their last value and are don't-care.
- Ordering is strictly FIFO. Nothing is dropped or duplicated.
- Downstream rule: while `ow_valid & ~iw_ready`, `ow_pc`/`ow_instr`/`ow_valid` hold stable.
- Upstream obligation: while `iw_valid & ~ow_ready`, hold `iw_*` stable.
- Flush (when compiled in) has the highest priority:
  - State goes to EMPTY.
  - M and S are cleared to pc=0 and instr=`NOP_INSTR`.
  - A same-cycle accept-in is discarded.
  - A same-cycle accept-out still counts as consumed downstream.
- No arithmetic. Widths pass through unchanged.

## Timing
- Reset (`iw_rst_n` = 0, asynchronous):
  - State is EMPTY.
  - `ow_valid`=0, `ow_ready`=1, `ow_skid`=0.
  - `ow_pc`=0, `ow_instr`=`NOP_INSTR`; S holds the same values.
- Release of reset is synchronous to `iw_clk`. Reset asserted mid-transfer drops all held payload immediately.
- Latency: an input accepted in cycle n appears with `ow_valid`=1 in cycle n+1 when the stage was EMPTY or BUSY with a simultaneous accept-out.
- Throughput: 1 transfer per cycle with `iw_ready` held at 1.
- Back-pressure: `ow_ready` falls one cycle after the second un-drained acceptance. S absorbs the in-flight beat.
- Recovery: `ow_ready` rises in the cycle after the accept-out that leaves FULL.
- Flush: effect is visible in cycle n+1. `ow_valid`=0 and `ow_ready`=1 from then on.

## Configuration
- `STGREG_FLUSH_EN` defined: the `iw_flush` port exists and behaves as specified above.
- `STGREG_FLUSH_EN` undefined: there is no `iw_flush` port and no flush logic. State changes only through the handshake and reset.

## Structure
- `SIZE_ADDR`, `SIZE_DATA` and the `HBIT_*` constants come from the shared `src2/sizes.vh`.
- Add the state encodings `STGREG_EMPTY`/`STGREG_BUSY`/`STGREG_FULL` (2 bits) to the same shared header.
- One sub-module is natural: `stgreg_slot`. It is a pc+instr register with load enable, asynchronous active-low reset to {0, `NOP_INSTR`}, and an optional synchronous clear. It is instantiated twice, once for M and once for S.

## Test plan
- Reset, then release, with `iw_valid`=0 → `ow_valid`=0, `ow_ready`=1, `ow_instr`=`NOP_INSTR`, `ow_pc`=0.
- Stream pc 0x10, 0x14, 0x18 on consecutive cycles with `iw_ready`=1 → each appears one cycle later; `ow_ready` stays 1 and `ow_skid` stays 0.
- Hold `iw_ready`=0 and offer 0x20, 0x24, 0x28 → 0x20 and 0x24 are accepted and `ow_ready`=0 from the next cycle. Release `iw_ready` → output order is 0x20, 0x24, then 0x28, with no loss.
- Drive `iw_flush`=1 while FULL (with `STGREG_FLUSH_EN`) together with a valid input 0x30 → next cycle `ow_valid`=0, `ow_ready`=1, `ow_instr`=`NOP_INSTR`; 0x30 never appears.
- Pulse `iw_rst_n` low asynchronously between clock edges while BUSY → outputs go to their reset values immediately, without waiting for a clock edge.
- Randomise `iw_valid`/`iw_ready` for 1000 beats against a scoreboard → in-order, lossless delivery, and the output-stability rule is never violated.
